// File: rtl/minn_pkg.sv
`default_nettype none
// ============================================================================
// Package : minn_pkg
// Brief   : FSM/segment types and saturating negation for minn_preamble_gen.
// Rev     : 1.0
// ============================================================================
package minn_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    typedef logic [1:0] seg_t;

    localparam int c_MAX_W = 64;

    // Operand is sign-extended to c_MAX_W. The caller truncates the result
    // back to `width` bits. Only the most negative value saturates.
    function automatic logic [c_MAX_W-1:0] sat_neg(input logic [c_MAX_W-1:0] x,
                                                   input int                 width);
        logic [c_MAX_W-1:0] min_val;
        min_val = {c_MAX_W{1'b1}} << (width - 1);
        if (x == min_val) begin
            sat_neg = ~min_val;
        end else begin
            sat_neg = -x;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/minn_preamble_gen.sv
`default_nettype none
// ============================================================================
// Module : minn_preamble_gen
// Brief  : Plays a Minn preamble (+A, +A, -A, -A) from a loadable A memory.
// Rev    : 1.0
// ============================================================================
module minn_preamble_gen
    import minn_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int QUARTER_LEN = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    input  logic signed [WIDTH-1:0] load_i,
    input  logic signed [WIDTH-1:0] load_q,
    input  logic                    start,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_i,
    output logic signed [WIDTH-1:0] out_q,
    output logic                    busy,
    output logic                    done
);

    localparam int                 c_IDX_W    = $clog2(QUARTER_LEN);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(QUARTER_LEN - 1);

    generate
        if (QUARTER_LEN < 2) begin : g_bad_quarter_len
            $error("minn_preamble_gen: QUARTER_LEN must be >= 2");
        end
        if (WIDTH < 2 || WIDTH >= c_MAX_W) begin : g_bad_width
            $error("minn_preamble_gen: WIDTH must be in 2..63");
        end
    endgenerate

    (* ram_style = "distributed" *) logic [2*WIDTH-1:0] r_mem [QUARTER_LEN];

    state_t                    r_state;
    state_t                    w_state_next;
    logic [c_IDX_W-1:0]        r_load_ptr;
    logic                      r_loaded;
    logic [c_IDX_W-1:0]        r_idx;
    seg_t                      r_seg;
    logic                      r_out_valid;
    logic signed [WIDTH-1:0]   r_out_i;
    logic signed [WIDTH-1:0]   r_out_q;
    logic                      r_done;
    logic                      r_shadow_valid;
    logic [c_IDX_W-1:0]        r_shadow_addr;
    logic [2*WIDTH-1:0]        r_shadow_data;

    logic                      w_load_ok;
    logic                      w_start_ok;
    logic                      w_accept;
    logic                      w_last;
    logic [c_IDX_W-1:0]        w_rd_idx;
    seg_t                      w_rd_seg;
    logic [2*WIDTH-1:0]        w_rd_word;
    logic signed [WIDTH-1:0]   w_rd_i;
    logic signed [WIDTH-1:0]   w_rd_q;
    logic signed [WIDTH-1:0]   w_smp_i;
    logic signed [WIDTH-1:0]   w_smp_q;

    assign w_load_ok  = load_valid && (r_state == IDLE);
    assign w_start_ok = start && (r_state == IDLE) && r_loaded;
    assign w_accept   = r_out_valid && out_ready;
    assign w_last     = (r_seg == 2'd3) && (r_idx == c_LAST_IDX);

    // Index/segment of the sample to present after this edge.
    always_comb begin
        w_rd_idx = '0;
        w_rd_seg = '0;
        if (!w_start_ok) begin
            if (r_idx == c_LAST_IDX) begin
                w_rd_idx = '0;
                w_rd_seg = r_seg + 2'd1;
            end else begin
                w_rd_idx = r_idx + c_IDX_W'(1);
                w_rd_seg = r_seg;
            end
        end
    end

    // A write coinciding with start is shadowed so it cannot alter this preamble.
    assign w_rd_word = (r_shadow_valid && !w_start_ok && (r_shadow_addr == w_rd_idx))
                       ? r_shadow_data : r_mem[w_rd_idx];
    assign w_rd_i    = w_rd_word[2*WIDTH-1:WIDTH];
    assign w_rd_q    = w_rd_word[WIDTH-1:0];

    assign w_smp_i = w_rd_seg[1]
        ? WIDTH'(sat_neg({{(c_MAX_W-WIDTH){w_rd_i[WIDTH-1]}}, w_rd_i}, WIDTH)) : w_rd_i;
    assign w_smp_q = w_rd_seg[1]
        ? WIDTH'(sat_neg({{(c_MAX_W-WIDTH){w_rd_q[WIDTH-1]}}, w_rd_q}, WIDTH)) : w_rd_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start_ok)          w_state_next = PLAY;
            PLAY:    if (w_accept && w_last)  w_state_next = IDLE;
            default:                          w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == PLAY);
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_load_ok) begin
            r_mem[r_load_ptr] <= {load_i, load_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_load_ptr     <= '0;
            r_loaded       <= 1'b0;
            r_idx          <= '0;
            r_seg          <= '0;
            r_out_valid    <= 1'b0;
            r_out_i        <= '0;
            r_out_q        <= '0;
            r_done         <= 1'b0;
            r_shadow_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load_ok) begin
                r_load_ptr <= (r_load_ptr == c_LAST_IDX) ? '0 : r_load_ptr + c_IDX_W'(1);
                if (r_load_ptr == c_LAST_IDX) begin
                    r_loaded <= 1'b1;
                end
            end
            if (w_start_ok) begin
                r_shadow_valid <= w_load_ok;
                r_shadow_addr  <= r_load_ptr;
                r_shadow_data  <= r_mem[r_load_ptr];
            end
            if (w_start_ok || (w_accept && !w_last)) begin
                r_idx       <= w_rd_idx;
                r_seg       <= w_rd_seg;
                r_out_valid <= 1'b1;
                r_out_i     <= w_smp_i;
                r_out_q     <= w_smp_q;
            end else if (w_accept && w_last) begin
                r_idx       <= '0;
                r_seg       <= '0;
                r_out_valid <= 1'b0;
                r_done      <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_i     = r_out_i;
    assign out_q     = r_out_q;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_minn_preamble_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_minn_preamble_gen
// Brief  : Self-checking bench for minn_preamble_gen against a sequence model.
// Rev    : 1.0
// ============================================================================
module tb_minn_preamble_gen;

    localparam int WIDTH = 16;
    localparam int QL    = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    load_valid;
    logic signed [WIDTH-1:0] load_i;
    logic signed [WIDTH-1:0] load_q;
    logic                    start;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_i;
    logic signed [WIDTH-1:0] out_q;
    logic                    busy;
    logic                    done;

    minn_preamble_gen #(.WIDTH(WIDTH), .QUARTER_LEN(QL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_i     (load_i),
        .load_q     (load_q),
        .start      (start),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_i      (out_i),
        .out_q      (out_q),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Model: A memory contents, load pointer, and the queue of samples still owed.
    int m_i [QL];
    int m_q [QL];
    int m_ptr = 0;
    int exp_i [$];
    int exp_q [$];
    int got_i [$];
    int got_q [$];
    bit rand_ready = 1'b0;
    bit done_exp   = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int sneg(input int v);
        if (v == -(1 << (WIDTH - 1))) return (1 << (WIDTH - 1)) - 1;
        return -v;
    endfunction

    task automatic push_preamble();
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < QL; k++) begin
                exp_i.push_back((s < 2) ? m_i[k] : sneg(m_i[k]));
                exp_q.push_back((s < 2) ? m_q[k] : sneg(m_q[k]));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_sample(input int li, input int lq);
        load_valid = 1'b1;
        load_i     = WIDTH'(li);
        load_q     = WIDTH'(lq);
        m_i[m_ptr] = li;
        m_q[m_ptr] = lq;
        m_ptr      = (m_ptr + 1) % QL;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_start(input bit accepted, input bit with_load, input int li, input int lq);
        if (accepted) push_preamble();
        start = 1'b1;
        if (with_load) begin
            load_valid = 1'b1;
            load_i     = WIDTH'(li);
            load_q     = WIDTH'(lq);
            m_i[m_ptr] = li;
            m_q[m_ptr] = lq;
            m_ptr      = (m_ptr + 1) % QL;
        end
        tick();
        start      = 1'b0;
        load_valid = 1'b0;
    endtask

    // Returns at the falling edge of the done cycle.
    task automatic wait_done(output int at_cyc);
        at_cyc = -1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (done) begin
                at_cyc = cyc;
                break;
            end
        end
        if (at_cyc < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: no done pulse within 1000 cycles, required one");
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Per-cycle compare against the expected-sample queue.
    initial begin
        bit hold = 1'b0;
        int hi = 0;
        int hq = 0;
        int ei, eq;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold     = 1'b0;
                done_exp = 1'b0;
            end else begin
                check("done_pulse", done, done_exp);
                done_exp = 1'b0;
                if (hold) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_i", out_i, hi);
                    check("hold_q", out_q, hq);
                end
                if (out_valid) check("busy_while_valid", busy, 1);
                if (done)      check("busy_on_done", busy, 0);
                if (out_valid && exp_i.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL stray_sample: got valid i=%0d, required no output", out_i);
                end else if (out_valid && out_ready) begin
                    ei = exp_i.pop_front();
                    eq = exp_q.pop_front();
                    check("sample_i", out_i, ei);
                    check("sample_q", out_q, eq);
                    got_i.push_back(int'(out_i));
                    got_q.push_back(int'(out_q));
                    if (exp_i.size() == 0) done_exp = 1'b1;
                end
                hold = out_valid && !out_ready;
                hi   = int'(out_i);
                hq   = int'(out_q);
            end
        end
    end

    initial begin
        int c0, dc, b;
        rst_n      = 1'b0;
        start      = 1'b0;
        load_valid = 1'b0;
        load_i     = '0;
        load_q     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_i", out_i, 0);
        check("rst_out_q", out_q, 0);
        tick();

        // Nothing loaded, then only 15 of 16 loaded: start must be ignored.
        do_start(1'b0, 1'b0, 0, 0);
        for (int k = 0; k < QL - 1; k++) load_sample(k + 1, 0);
        do_start(1'b0, 1'b0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            check("partial_load_busy", busy, 0);
            check("partial_load_valid", out_valid, 0);
        end
        tick();
        load_sample(16, 0);

        // A = 1..16, full-rate ready; cycles counted with the start cycle as 1.
        b  = got_i.size();
        c0 = cyc;
        do_start(1'b1, 1'b0, 0, 0);
        wait_done(dc);
        check("done_cycle", dc - c0 + 1, 66);
        check("done_out_valid", out_valid, 0);
        check("done_hold_last_i", out_i, -16);
        check("count_basic", got_i.size() - b, 64);
        check("lit_a0", got_i[b], 1);
        check("lit_a15", got_i[b + 15], 16);
        check("lit_seg1_a0", got_i[b + 16], 1);
        check("lit_seg2_a0", got_i[b + 32], -1);
        check("lit_seg3_a15", got_i[b + 63], -16);
        tick();

        // Saturation corners.
        for (int k = 0; k < QL; k++) begin
            if (k == 3)      load_sample(-32768, 32767);
            else if (k == 5) load_sample(32767, -32768);
            else             load_sample(100 * (k + 1), -7 * (k + 1));
        end
        b = got_i.size();
        do_start(1'b1, 1'b0, 0, 0);
        wait_done(dc);
        check("sat_seg0_i3", got_i[b + 3], -32768);
        check("sat_seg2_i3", got_i[b + 35], 32767);
        check("sat_seg3_i3", got_i[b + 51], 32767);
        check("sat_seg2_i5", got_i[b + 37], -32767);
        check("sat_seg2_q5", got_q[b + 37], 32767);
        check("sat_seg2_q3", got_q[b + 35], -32767);
        tick();

        // Random backpressure on A = 1..16.
        for (int k = 0; k < QL; k++) load_sample(k + 1, 0);
        rand_ready = 1'b1;
        b = got_i.size();
        do_start(1'b1, 1'b0, 0, 0);
        wait_done(dc);
        rand_ready = 1'b0;
        check("count_random", got_i.size() - b, 64);
        check("lit_random_47", got_i[b + 47], -16);
        tick();

        // Ignored mid-preamble start; start on the done cycle with a coinciding load.
        do_start(1'b1, 1'b0, 0, 0);
        repeat (10) tick();
        do_start(1'b0, 1'b0, 0, 0);
        wait_done(dc);
        b = got_i.size();
        do_start(1'b1, 1'b1, 999, -999);
        @(negedge clk);
        check("b2b_valid", out_valid, 1);
        check("b2b_first_i", out_i, 1);
        wait_done(dc);
        check("b2b_seg2_a0_old", got_i[b + 32], -1);
        tick();
        b = got_i.size();
        do_start(1'b1, 1'b0, 0, 0);
        wait_done(dc);
        check("reload_a0_i", got_i[b], 999);
        check("reload_seg2_a0_q", got_q[b + 32], 999);
        tick();

        // Reset mid-preamble at sample 20.
        b = got_i.size();
        do_start(1'b1, 1'b0, 0, 0);
        for (int n = 0; n < 200 && got_i.size() < b + 20; n++) tick();
        rst_n = 1'b0;
        tick();
        exp_i.delete();
        exp_q.delete();
        m_ptr = 0;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_i", out_i, 0);
        check("midrst_q", out_q, 0);
        tick();
        do_start(1'b0, 1'b0, 0, 0);
        repeat (5) begin
            @(negedge clk);
            check("post_rst_no_busy", busy, 0);
            check("post_rst_no_done", done, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
